// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: fetch sequencer for the RV32I instruction ROM.
// Owns the program counter and drives the ROM address. It tracks the ROM's
// 1-cycle read latency and delivers {instr, pc, err} entries to decode over a
// valid/ready stream, buffered in a 2-entry FIFO.
// Ports:
//   clock, reset       - system clock; asynchronous active-high reset
//   run                - 1 = new fetches may be issued
//   redirect_valid/pc  - single-cycle fetch restart request (pc[1:0] ignored)
//   rom_pc             - combinational byte address to the ROM
//   rom_instr          - ROM data for the address latched on the previous edge
//   out_valid/ready    - output handshake; out_instr/out_pc/out_err = FIFO head
//   fetch_count        - number of accepted handshakes (wraps)
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_WORDS = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] rom_pc,
  input  logic [31:0] rom_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_err,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] ROM_LIMIT = 32'(ROM_WORDS * 4);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
  } entry_t;

  logic [31:0] fetch_pc;
  logic        inflight;
  logic [31:0] inflight_pc;
  logic [1:0]  count;
  entry_t      buf0, buf1;

  logic [31:0] target;
  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occ;
  entry_t      new_entry;

  assign target    = redirect_pc & ~32'd3;
  assign rom_pc    = redirect_valid ? target : fetch_pc;
  assign out_valid = (count != 2'd0);
  assign out_instr = buf0.instr;
  assign out_pc    = buf0.pc;
  assign out_err   = buf0.err;

  always_comb begin
    pop  = out_valid && out_ready;
    occ  = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    // A redirect flushes everything, so its target may always issue.
    issue = redirect_valid ? run : (run && (occ < 3'd2));
    push  = inflight && !redirect_valid;
    // The ROM aliases high addresses, so out-of-range returns are replaced.
    if (inflight_pc >= ROM_LIMIT) new_entry = '{instr: NOP_INSTR, pc: inflight_pc, err: 1'b1};
    else                          new_entry = '{instr: rom_instr, pc: inflight_pc, err: 1'b0};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= '0;
      buf0        <= '0;
      buf1        <= '0;
      fetch_count <= '0;
    end else begin
      if (pop) fetch_count <= fetch_count + 32'd1;

      inflight <= issue;
      if (issue) begin
        inflight_pc <= rom_pc;
        fetch_pc    <= rom_pc + 32'd4;
      end else if (redirect_valid) begin
        fetch_pc <= target;
      end

      if (redirect_valid) begin
        count <= '0;
      end else begin
        case ({push, pop})
          2'b01: begin
            buf0  <= buf1;
            count <= count - 2'd1;
          end
          2'b10: begin
            if (count == 2'd0) buf0 <= new_entry;
            else               buf1 <= new_entry;
            count <= count + 2'd1;
          end
          2'b11: begin
            if (count == 2'd1) buf0 <= new_entry;
            else begin
              buf0 <= buf1;
              buf1 <= new_entry;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Fetch sequencer for the 32-word RV32I instruction ROM. The ROM has a synchronous address register and an unregistered output.
- Owns the program counter and drives the ROM byte address. Tracks the ROM's 1-cycle read latency and delivers instructions tagged with their PC over a valid/ready stream to the decode stage.
- Handles back-pressure through a 2-entry output buffer, branch/jump redirects, halting and out-of-range detection.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ROM_WORDS, 32, number of implemented ROM words. Byte addresses at or above ROM_WORDS*4 are out of range.
- NOP_INSTR, 32'h0000_0013, instruction substituted for out-of-range fetches (ADDI x0,x0,0).

Ports:
- clock, input, 1, single system clock; all state changes on the rising edge.
- reset, input, 1, asynchronous, active-high. Asserts immediately; deassertion is sampled on clock.
- run, input, 1, 1 = new fetches may be issued; 0 = halt issuing.
- redirect_valid, input, 1, single-cycle request to restart fetch at redirect_pc.
- redirect_pc, input, 32, redirect target byte address; bits [1:0] are ignored (forced to 0).
- rom_pc, output, 32, byte address to the ROM PC input, combinational.
- rom_instr, input, 32, ROM INSTR output; valid in the cycle after the address edge.
- out_valid, output, 1, out_instr/out_pc/out_err hold a valid entry.
- out_ready, input, 1, consumer accepts the entry when out_valid && out_ready at a rising edge.
- out_instr, output, 32, fetched instruction.
- out_pc, output, 32, byte address of out_instr.
- out_err, output, 1, entry came from an out-of-range PC; out_instr = NOP_INSTR.
- fetch_count, output, 32, number of accepted handshakes; wraps at 2^32.

Behaviour:
- Reset values:
  - fetch_pc = RESET_PC.
  - inflight = 0.
  - buffer count = 0.
  - out_valid = 0; out_instr = 0; out_pc = 0; out_err = 0.
  - fetch_count = 0.
  - Reset mid-operation discards all in-flight and buffered entries.
- Address drive: rom_pc = redirect_valid ? {redirect_pc[31:2],2'b00} : fetch_pc.
- Read pipeline:
  - The ROM latches rom_pc at edge E. rom_instr for that address is sampled at edge E+1.
  - An entry written at E+1 is visible on out_* in the following cycle.
- pop = out_valid && out_ready.
- Issue condition: issue = run && (count + inflight - pop < 2).
  - Evaluated combinationally.
  - This gives full throughput of one instruction per cycle while out_ready stays high.
- On issue, at the edge:
  - inflight <= 1 and inflight_pc <= rom_pc.
  - fetch_pc <= rom_pc + 4, using 32-bit wrap.
- With no issue: inflight <= 0 and fetch_pc holds. The ROM still latches rom_pc, but the result is ignored.
- Return capture: if inflight is set at an edge and no redirect occurs, the buffer pushes {rom_instr, inflight_pc, err=0}.
  - If inflight_pc >= ROM_WORDS*4, it pushes {NOP_INSTR, inflight_pc, err=1} instead.
  - The ROM aliases high addresses; the controller must flag them rather than pass the aliased data.
- Buffer: 2-entry FIFO, head drives out_*.
  - Push and pop in the same edge are both performed.
  - Overflow is impossible by the issue rule. The bench asserts count never exceeds 2.
- Redirect (redirect_valid = 1 at an edge):
  - The buffer is flushed to count 0.
  - The old in-flight return is discarded.
  - If run = 1, the target is issued in the same edge: inflight <= 1, inflight_pc = target, fetch_pc <= target + 4.
  - A pop in the same cycle still counts as accepted and increments fetch_count.
  - The target instruction appears with out_valid = 1 two cycles after the redirect cycle.
  - If run = 0, fetch_pc <= target, and nothing is issued until run rises.
- Halt: run = 0 stops new issues only. An in-flight read completes into the buffer, and buffered entries drain normally.
- out_* are held stable while out_valid && !out_ready.
- fetch_count increments by 1 on each pop.

Test Plan:
- Reset release, run = 1, out_ready = 1, ROM word0..2 = 0x00500093, 0x00A00113, 0x002081B3:
  - cycle 2 after release: out_valid = 1, pc = 0, instr = 0x00500093.
  - then pc 4 and pc 8 on consecutive cycles.
  - fetch_count = 3 after three handshakes.
- Back-pressure: out_ready = 0 for 5 cycles from steady flow.
  - out_pc holds its value; count reaches 2; rom_pc advances at most 2 words beyond out_pc.
  - After out_ready = 1, pcs continue with no gap or duplicate.
- Redirect: redirect_pc = 0x0000_0042 while entries are buffered.
  - The next valid entry is pc 0x40, exactly 2 cycles later. No stale pc appears.
  - The redirect-cycle pop is counted in fetch_count.
- Out-of-range: redirect_pc = 0x0000_007C, run continues.
  - pc 0x7C: err = 0, ROM data.
  - pc 0x80: err = 1, instr = 0x00000013.
  - pc 0x84: err = 1.
- Halt: run = 0 mid-stream. Exactly the buffered and in-flight entries drain, then out_valid = 0. run = 1 resumes at the next sequential pc.
- Asynchronous reset asserted mid-cycle during flow:
  - out_valid drops to 0 immediately, before the next edge.
  - After release, fetch restarts at RESET_PC with fetch_count = 0.
